// File: rtl/aes_key_schedule_128.sv
// aes_key_schedule_128
//   Iterative AES-128 key expansion. Pops one 128-bit cipher key from an
//   upstream FIFO and pushes the round keys 0..NUM_ROUNDS to a downstream
//   FIFO, one per cycle, with back-to-back key loading at the final round.
//
// Ports
//   clock         rising-edge clock
//   reset         synchronous, active-low reset
//   in_key        cipher key, byte i = in_key[i*8 +: 8] (byte 0 = first FIPS byte)
//   in_key_rd     pop strobe to upstream FIFO
//   in_key_empty  upstream FIFO empty
//   out_key       current round key, same byte packing as in_key
//   out_key_wr    push strobe to downstream FIFO
//   out_key_full  downstream FIFO full
//   out_round     round index of out_key
module aes_key_schedule_128 #(
  parameter int NUM_ROUNDS  = 10,
  parameter int EMIT_ROUND0 = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] in_key,
  output logic         in_key_rd,
  input  logic         in_key_empty,
  output logic [127:0] out_key,
  output logic         out_key_wr,
  input  logic         out_key_full,
  output logic [3:0]   out_round
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state, state_nxt;
  logic [127:0] rk, rk_nxt, rk_step;
  logic [3:0]   rnd, rnd_nxt;
  logic [7:0]   rcon, rcon_nxt;
  logic [31:0]  t, w0n, w1n, w2n, w3n;
  logic         last_rnd;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed algebraically: multiplicative inverse as x^254 (0 maps
  // to 0), followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // w3 holds bytes 12..15 (byte 12 in the low bits). RotWord moves byte 13
  // into position 0, so t = {S(b12), S(b15), S(b14), S(b13)^rcon}.
  assign t = {sbox(rk[103:96]), sbox(rk[127:120]), sbox(rk[119:112]),
              sbox(rk[111:104]) ^ rcon};

  always_comb begin
    w0n = rk[31:0]   ^ t;
    w1n = rk[63:32]  ^ w0n;
    w2n = rk[95:64]  ^ w1n;
    w3n = rk[127:96] ^ w2n;
  end

  assign rk_step   = {w3n, w2n, w1n, w0n};
  assign last_rnd  = (rnd == LAST_RND);
  assign out_key   = rk;
  assign out_round = rnd;

  always_comb begin
    state_nxt  = state;
    rk_nxt     = rk;
    rnd_nxt    = rnd;
    rcon_nxt   = rcon;
    in_key_rd  = reset && !in_key_empty &&
                 ((state == IDLE) || (last_rnd && !out_key_full));
    out_key_wr = reset && (state == RUN) && !out_key_full &&
                 ((EMIT_ROUND0 != 0) || (rnd != 4'd0));
    if (in_key_rd) begin
      state_nxt = RUN;
      rk_nxt    = in_key;
      rnd_nxt   = 4'd0;
      rcon_nxt  = 8'h01;
    end else if ((state == RUN) && !out_key_full) begin
      if (last_rnd) begin
        state_nxt = IDLE;
      end else begin
        rk_nxt   = rk_step;
        rnd_nxt  = rnd + 4'd1;
        rcon_nxt = xtime(rcon);
      end
    end
  end

  // Round-key register stage
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      rk    <= '0;
      rnd   <= 4'd0;
      rcon  <= 8'h01;
    end else begin
      state <= state_nxt;
      rk    <= rk_nxt;
      rnd   <= rnd_nxt;
      rcon  <= rcon_nxt;
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_128.sv
// tb_aes_key_schedule_128
//   Directed bench for aes_key_schedule_128 using the FIPS-197 key expansion
//   vectors. A second instance covers EMIT_ROUND0=0.
module tb_aes_key_schedule_128;

  logic         clock = 1'b0;
  logic         reset;
  logic [127:0] in_key;
  logic         in_key_rd;
  logic         in_key_empty;
  logic [127:0] out_key;
  logic         out_key_wr;
  logic         out_key_full;
  logic [3:0]   out_round;

  logic [127:0] in_key2;
  logic         in_key_rd2;
  logic         in_key_empty2;
  logic [127:0] out_key2;
  logic         out_key_wr2;
  logic         out_key_full2;
  logic [3:0]   out_round2;

  aes_key_schedule_128 #(.NUM_ROUNDS(10), .EMIT_ROUND0(1)) dut (
    .clock(clock), .reset(reset),
    .in_key(in_key), .in_key_rd(in_key_rd), .in_key_empty(in_key_empty),
    .out_key(out_key), .out_key_wr(out_key_wr), .out_key_full(out_key_full),
    .out_round(out_round)
  );

  aes_key_schedule_128 #(.NUM_ROUNDS(10), .EMIT_ROUND0(0)) dut_nr0 (
    .clock(clock), .reset(reset),
    .in_key(in_key2), .in_key_rd(in_key_rd2), .in_key_empty(in_key_empty2),
    .out_key(out_key2), .out_key_wr(out_key_wr2), .out_key_full(out_key_full2),
    .out_round(out_round2)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [127:0] fr [0:10];
  logic [127:0] kq [$];
  logic [127:0] wr_key [$];
  int           wr_rnd [$];
  int           wr_cyc [$];
  int           rd_cyc [$];
  logic [127:0] w2_key [$];
  int           w2_rnd [$];
  logic         rd_q, rd2_q;
  logic [127:0] junk;
  int           rst_cyc;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // FIPS byte string (first byte in the MSBs of the literal) to bus packing.
  function automatic logic [127:0] bus(input logic [127:0] f);
    logic [127:0] b;
    for (int i = 0; i < 16; i++) b[i*8 +: 8] = f[(15-i)*8 +: 8];
    return b;
  endfunction

  task automatic refresh();
    in_key_empty = (kq.size() == 0);
    in_key       = (kq.size() > 0) ? kq[0] : '0;
  endtask

  task automatic clear_log();
    wr_key.delete(); wr_rnd.delete(); wr_cyc.delete(); rd_cyc.delete();
    w2_key.delete(); w2_rnd.delete();
  endtask

  // Sample outputs on the falling edge, then model FIFO pops after the edge.
  task automatic tick();
    @(negedge clock);
    if (out_key_wr) begin
      wr_key.push_back(out_key); wr_rnd.push_back(int'(out_round)); wr_cyc.push_back(cyc);
    end
    if (in_key_rd) rd_cyc.push_back(cyc);
    if (out_key_wr2) begin
      w2_key.push_back(out_key2); w2_rnd.push_back(int'(out_round2));
    end
    rd_q  = in_key_rd;
    rd2_q = in_key_rd2;
    cyc++;
    @(posedge clock);
    #1;
    if (rd_q && kq.size() > 0) junk = kq.pop_front();
    if (rd2_q) in_key_empty2 = 1'b1;
    refresh();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    fr[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fr[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fr[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fr[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fr[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fr[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fr[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fr[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fr[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fr[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fr[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    reset = 1'b0; out_key_full = 1'b0; out_key_full2 = 1'b0;
    in_key2 = '0; in_key_empty2 = 1'b1;
    refresh();
    tick(); tick();
    check("rst out_round", out_round, 0);
    check("rst out_key", out_key, 0);
    check("rst in_key_rd", in_key_rd, 0);
    check("rst out_key_wr", out_key_wr, 0);
    check("rst nr0 out_round", out_round2, 0);
    reset = 1'b1;
    tick();

    // A: single FIPS key, no backpressure; EMIT_ROUND0=0 instance in parallel
    clear_log();
    kq.push_back(bus(fr[0])); refresh();
    in_key2 = bus(fr[0]); in_key_empty2 = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("A writes", wr_key.size(), 11);
    check("A reads", rd_cyc.size(), 1);
    if (wr_key.size() == 11 && rd_cyc.size() == 1) begin
      check("A latency", wr_cyc[0], rd_cyc[0] + 1);
      for (int k = 0; k <= 10; k++) begin
        check($sformatf("A rk%0d", k), wr_key[k], bus(fr[k]));
        check($sformatf("A rnd%0d", k), wr_rnd[k], k);
        check($sformatf("A cyc%0d", k), wr_cyc[k], wr_cyc[0] + k);
      end
    end
    check("A nr0 writes", w2_key.size(), 10);
    if (w2_key.size() == 10) begin
      for (int k = 0; k < 10; k++) begin
        check($sformatf("A nr0 rk%0d", k + 1), w2_key[k], bus(fr[k + 1]));
        check($sformatf("A nr0 rnd%0d", k + 1), w2_rnd[k], k + 1);
      end
    end

    // B: two keys queued back-to-back
    clear_log();
    kq.push_back(bus(fr[0])); kq.push_back('0); refresh();
    for (int i = 0; i < 30; i++) tick();
    check("B writes", wr_key.size(), 22);
    check("B reads", rd_cyc.size(), 2);
    if (wr_key.size() == 22 && rd_cyc.size() == 2) begin
      for (int k = 0; k < 22; k++) begin
        check($sformatf("B rnd%0d", k), wr_rnd[k], k % 11);
        check($sformatf("B cyc%0d", k), wr_cyc[k], wr_cyc[0] + k);
      end
      check("B k1 rk10", wr_key[10], bus(fr[10]));
      check("B k2 rk0", wr_key[11], 0);
      check("B k2 rk1", wr_key[12], bus(128'h62636363626363636263636362636363));
      check("B rd with final wr", rd_cyc[1], wr_cyc[10]);
    end

    // C: downstream full for 3 cycles while round 4 is pending
    clear_log();
    kq.push_back(bus(fr[0])); refresh();
    for (int i = 0; i < 30 && out_round != 4'd4; i++) tick();
    check("C reach rnd4", out_round, 4);
    out_key_full = 1'b1;
    #1;
    check("C stall wr", out_key_wr, 0);
    for (int s = 0; s < 2; s++) begin
      tick();
      check($sformatf("C stall%0d rnd", s), out_round, 4);
      check($sformatf("C stall%0d key", s), out_key, bus(fr[4]));
      check($sformatf("C stall%0d wr", s), out_key_wr, 0);
    end
    tick();
    out_key_full = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("C writes", wr_key.size(), 11);
    if (wr_key.size() == 11) begin
      for (int k = 0; k <= 10; k++) begin
        check($sformatf("C rk%0d", k), wr_key[k], bus(fr[k]));
        check($sformatf("C rnd%0d", k), wr_rnd[k], k);
      end
      check("C stall gap", wr_cyc[4], wr_cyc[3] + 4);
      check("C after stall", wr_cyc[5], wr_cyc[4] + 1);
    end

    // D: reset pulse at round 6, then a fresh key
    clear_log();
    kq.push_back(bus(fr[0])); refresh();
    for (int i = 0; i < 30 && out_round != 4'd6; i++) tick();
    check("D reach rnd6", out_round, 6);
    reset = 1'b0;
    kq.push_back('0); refresh();
    #1;
    check("D rst rd", in_key_rd, 0);
    check("D rst wr", out_key_wr, 0);
    rst_cyc = cyc;
    tick();
    reset = 1'b1;
    #1;
    check("D idle rnd", out_round, 0);
    check("D idle key", out_key, 0);
    check("D idle rd", in_key_rd, 1);
    for (int i = 0; i < 15; i++) tick();
    check("D writes", wr_key.size(), 17);
    if (wr_key.size() == 17) begin
      check("D last pre rnd", wr_rnd[5], 5);
      check("D last pre cyc", wr_cyc[5], rst_cyc - 1);
      check("D new rnd0", wr_rnd[6], 0);
      check("D new rk0", wr_key[6], 0);
      check("D new cyc", wr_cyc[6], rst_cyc + 2);
      check("D new rk1", wr_key[7], bus(128'h62636363626363636263636362636363));
      check("D new rnd10", wr_rnd[16], 10);
    end

    // E: idle with empty upstream
    clear_log();
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("E rd%0d", i), in_key_rd, 0);
      check($sformatf("E wr%0d", i), out_key_wr, 0);
    end
    check("E writes", wr_key.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
